// File: rtl/alu_issue.sv
// RV32I ALU-class decode/issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU operands and
// operation, held behind a valid/ready handshake with an optional two-entry skid buffer.
module alu_issue #(
  parameter bit SKID = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_operand1,
  output logic [31:0] out_operand2,
  output logic [3:0]  out_operation,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic        out_illegal,
  output logic [31:0] out_pc
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_OLUI = 4'd10;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  // ---------------- decode ----------------
  entry_t      dec;
  logic        legal;
  logic [31:0] d_op1, d_op2, imm_i, imm_u, shamt;
  logic [3:0]  d_op;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign shamt = {27'b0, in_instr[24:20]};

  always_comb begin
    legal = 1'b0;
    d_op1 = '0;
    d_op2 = '0;
    d_op  = ALU_ADD;
    case (opc)
      OPC_OP: begin
        d_op1 = in_rs1_data;
        d_op2 = in_rs2_data;
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
        case (f3)
          3'b000:  d_op = f7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  d_op = ALU_SLL;
          3'b010:  d_op = ALU_SLT;
          3'b011:  d_op = ALU_SLTU;
          3'b100:  d_op = ALU_XOR;
          3'b101:  d_op = f7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  d_op = ALU_OR;
          default: d_op = ALU_AND;
        endcase
      end
      OPC_IMM: begin
        d_op1 = in_rs1_data;
        d_op2 = imm_i;
        legal = 1'b1;
        case (f3)
          3'b000:  d_op = ALU_ADD;
          3'b001: begin
            d_op  = ALU_SLL;
            d_op2 = shamt;
            legal = (f7 == 7'h00);
          end
          3'b010:  d_op = ALU_SLT;
          3'b011:  d_op = ALU_SLTU;
          3'b100:  d_op = ALU_XOR;
          3'b101: begin
            d_op  = f7[5] ? ALU_SRA : ALU_SRL;
            d_op2 = shamt;
            legal = (f7 == 7'h00) || (f7 == 7'h20);
          end
          3'b110:  d_op = ALU_OR;
          default: d_op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        d_op2 = imm_u;
        d_op  = ALU_OLUI;
        legal = 1'b1;
      end
      OPC_AUIPC: begin
        d_op1 = in_pc;
        d_op2 = imm_u;
        legal = 1'b1;
      end
      default: ;
    endcase

    // Malformed encodings travel as a clean ADD 0,0 so trap logic sees a benign entry.
    dec.op1     = legal ? d_op1 : '0;
    dec.op2     = legal ? d_op2 : '0;
    dec.op      = legal ? d_op : ALU_ADD;
    dec.rd      = in_instr[11:7];
    dec.rd_we   = legal && (in_instr[11:7] != 5'd0);
    dec.illegal = !legal;
    dec.pc      = in_pc;
  end

  // ---------------- handshake / storage ----------------
  state_t state_q, state_d;
  entry_t main_q, skid_q, main_d;
  logic   fire, load_main, load_skid, main_from_skid;

  // With SKID=0 the ONE->FULL arc is unreachable: fire in ONE implies out_ready.
  assign in_ready = SKID ? (state_q != FULL) : (state_q == EMPTY || out_ready);
  assign fire     = in_valid && in_ready && !flush;
  assign main_d   = main_from_skid ? skid_q : dec;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (fire) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
        ONE: begin
          if (fire && !out_ready) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (fire) begin
            load_main = 1'b1;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: if (out_ready) begin
          state_d        = ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) main_q <= main_d;
      if (load_skid) skid_q <= dec;
    end
  end

  assign out_valid     = (state_q != EMPTY);
  assign out_operand1  = main_q.op1;
  assign out_operand2  = main_q.op2;
  assign out_operation = main_q.op;
  assign out_rd        = main_q.rd;
  assign out_rd_we     = main_q.rd_we;
  assign out_illegal   = main_q.illegal;
  assign out_pc        = main_q.pc;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue (SKID=1): decode vectors, skid back-pressure, flush,
// async reset and a randomized traffic run.
module tb_alu_issue;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                         A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                         A_OR = 4'd8, A_AND = 4'd9, A_OLUI = 4'd10;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic [31:0] pc;
  } ent_t;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic [31:0] out_operand1, out_operand2, out_pc;
  logic [3:0]  out_operation;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_illegal;

  int   n_chk, n_fail;
  ent_t sb[$];

  alu_issue #(.SKID(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_operand1(out_operand1),
    .out_operand2(out_operand2), .out_operation(out_operation), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ent_t dut_out();
    return '{out_operand1, out_operand2, out_operation, out_rd, out_rd_we, out_illegal, out_pc};
  endfunction

  function automatic ent_t mk(input logic [31:0] a, b, input logic [3:0] op, input logic [4:0] rd,
                              input logic we, ill, input logic [31:0] pc);
    return '{a, b, op, rd, we, ill, pc};
  endfunction

  function automatic logic [3:0] alu3(input logic [2:0] f3);
    case (f3)
      3'd0: return A_ADD;  3'd1: return A_SLL;  3'd2: return A_SLT;  3'd3: return A_SLTU;
      3'd4: return A_XOR;  3'd5: return A_SRL;  3'd6: return A_OR;   default: return A_AND;
    endcase
  endfunction

  // Independent reference decode.
  function automatic ent_t model(input logic [31:0] ins, pc, r1, r2);
    ent_t e; logic ok; logic [6:0] f7; logic [2:0] f3;
    f7 = ins[31:25]; f3 = ins[14:12];
    e = '0; e.pc = pc; e.rd = ins[11:7]; e.op = A_ADD; ok = 1'b0;
    if (ins[6:0] == 7'b0110011) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.op1 = r1; e.op2 = r2;
      e.op = (f3 == 3'd0) ? (f7[5] ? A_SUB : A_ADD) : (f3 == 3'd5) ? (f7[5] ? A_SRA : A_SRL) : alu3(f3);
    end else if (ins[6:0] == 7'b0010011) begin
      ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      e.op1 = r1;
      e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
      e.op = (f3 == 3'd5) ? (f7[5] ? A_SRA : A_SRL) : alu3(f3);
    end else if (ins[6:0] == 7'b0110111) begin
      ok = 1'b1; e.op2 = {ins[31:12], 12'b0}; e.op = A_OLUI;
    end else if (ins[6:0] == 7'b0010111) begin
      ok = 1'b1; e.op1 = pc; e.op2 = {ins[31:12], 12'b0};
    end
    if (!ok) begin e.op1 = '0; e.op2 = '0; e.op = A_ADD; end
    e.ill = !ok;
    e.we  = ok && (e.rd != 5'd0);
    return e;
  endfunction

  // One cycle of stimulus: drive at negedge, settle, then do scoreboard bookkeeping.
  task automatic step(input logic v, input logic [31:0] ins, pc, r1, r2, input ent_t e,
                      input logic ordy, input logic fl,
                      output logic rdy, output logic p, output ent_t got, output ent_t exp);
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
    out_ready = ordy; flush = fl;
    #1;
    rdy = in_ready;
    p   = out_valid && ordy && !fl;
    got = dut_out();
    exp = got;
    if (p) exp = (sb.size() > 0) ? sb.pop_front() : ~got;
    if (v && rdy && !fl) sb.push_back(e);
    if (fl) sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({out_valid, in_ready, dut_out()} !== {1'b0, 1'b1, ent_t'('0)}) begin
      n_fail++;
      $display("FAIL reset: got v=%b r=%b %h exp v=0 r=1 all-zero", out_valid, in_ready, dut_out());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] ti[10], tp[10], t1[10], t2[10];
    ent_t te[10];
    logic rdy, p; ent_t g, e;
    ti = '{32'hFFF08293, 32'h402081B3, 32'h40415093, 32'h123453B7, 32'h0000000B,
           32'h00208033, 32'h00001517, 32'h02208033, 32'h40109093, 32'hFFE13213};
    tp = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h11C, 32'h120, 32'h124};
    t1 = '{32'd5, 32'd10, 32'h80000000, 32'hDEAD, 32'd1, 32'd1, 32'd9, 32'd1, 32'd3, 32'd7};
    t2 = '{32'd0, 32'd3, 32'd7, 32'd4, 32'd2, 32'd2, 32'd9, 32'd2, 32'd3, 32'd0};
    te = '{mk(32'd5, 32'hFFFFFFFF, A_ADD, 5'd5, 1'b1, 1'b0, 32'h100),
           mk(32'd10, 32'd3, A_SUB, 5'd3, 1'b1, 1'b0, 32'h104),
           mk(32'h80000000, 32'd4, A_SRA, 5'd1, 1'b1, 1'b0, 32'h108),
           mk(32'd0, 32'h12345000, A_OLUI, 5'd7, 1'b1, 1'b0, 32'h10C),
           mk(32'd0, 32'd0, A_ADD, 5'd0, 1'b0, 1'b1, 32'h110),
           mk(32'd1, 32'd2, A_ADD, 5'd0, 1'b0, 1'b0, 32'h114),
           mk(32'h118, 32'h1000, A_ADD, 5'd10, 1'b1, 1'b0, 32'h118),
           mk(32'd0, 32'd0, A_ADD, 5'd0, 1'b0, 1'b1, 32'h11C),
           mk(32'd0, 32'd0, A_ADD, 5'd1, 1'b0, 1'b1, 32'h120),
           mk(32'd7, 32'hFFFFFFFE, A_SLTU, 5'd4, 1'b1, 1'b0, 32'h124)};
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) step(1'b1, ti[i], tp[i], t1[i], t2[i], te[i], 1'b1, 1'b0, rdy, p, g, e);
      else        step(1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b0, rdy, p, g, e);
      n_chk++;
      if (rdy !== 1'b1 || p !== (i > 0)) begin
        n_fail++;
        $display("FAIL decode_flow[%0d]: got in_ready=%b out_valid=%b exp 1/%b", i, rdy, p, i > 0);
      end
      if (p) begin
        n_chk++;
        if (g !== e) begin n_fail++; $display("FAIL decode[%0d]: got %h exp %h", i - 1, g, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic rdy, p; ent_t g, e, ea, eb, ec;
    ea = model(32'h00500093, 32'h200, 32'd0, 32'd0);   // addi x1,x0,5
    eb = model(32'h00209133, 32'h204, 32'd6, 32'd3);   // sll x2,x1,x2
    ec = model(32'h0020C1B3, 32'h208, 32'hF0, 32'h0F); // xor x3,x1,x2
    step(1'b1, 32'h00500093, 32'h200, 32'd0, 32'd0, ea, 1'b0, 1'b0, rdy, p, g, e);
    step(1'b1, 32'h00209133, 32'h204, 32'd6, 32'd3, eb, 1'b0, 1'b0, rdy, p, g, e);
    n_chk++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ready: got %b exp 1", rdy); end
    step(1'b1, 32'h0020C1B3, 32'h208, 32'hF0, 32'h0F, ec, 1'b0, 1'b0, rdy, p, g, e);
    n_chk++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b exp 0", rdy); end
    n_chk++;
    if (g !== ea) begin n_fail++; $display("FAIL b2b_stall_hold: got %h exp %h", g, ea); end
    for (int i = 0; i < 4; i++) begin
      step(i < 2, 32'h0020C1B3, 32'h208, 32'hF0, 32'h0F, ec, 1'b1, 1'b0, rdy, p, g, e);
      n_chk++;
      if (p !== (i < 3)) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b exp %b", i, p, i < 3); end
      if (p) begin
        n_chk++;
        if (g !== e) begin n_fail++; $display("FAIL b2b_order[%0d]: got %h exp %h", i, g, e); end
      end
    end
  endtask

  task automatic test_flush();
    logic rdy, p; ent_t g, e;
    // flush while FULL, then while ONE with an acceptable input on the wire
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2 - k; i++)
        step(1'b1, 32'h00100093 + i, 32'h300 + i, 32'd1, 32'd1,
             model(32'h00100093 + i, 32'h300 + i, 32'd1, 32'd1), 1'b0, 1'b0, rdy, p, g, e);
      step(1'b1, 32'h7FF00F93, 32'h3F0, 32'd0, 32'd0, model(32'h7FF00F93, 32'h3F0, 0, 0),
           1'b0, 1'b1, rdy, p, g, e);
      for (int i = 0; i < 3; i++) begin
        step(1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b0, rdy, p, g, e);
        n_chk++;
        if (p !== 1'b0 || rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL flush%0d[%0d]: got out_valid=%b in_ready=%b data=%h exp 0/1", k, i, p, rdy, g);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic rdy, p; ent_t g, e;
    for (int i = 0; i < 2; i++)
      step(1'b1, 32'h123453B7, 32'h400 + 4 * i, 32'd0, 32'd0,
           model(32'h123453B7, 32'h400 + 4 * i, 0, 0), 1'b0, 1'b0, rdy, p, g, e);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, in_ready, dut_out()} !== {1'b0, 1'b1, ent_t'('0)}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b r=%b %h exp v=0 r=1 all-zero", out_valid, in_ready, dut_out());
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic rdy, p, v, fl; ent_t g, e;
    logic [31:0] ins, pc, r1, r2;
    for (int i = 0; i < 400; i++) begin
      ins = $urandom; pc = $urandom; r1 = $urandom; r2 = $urandom;
      case ($urandom_range(0, 5))
        0: ins[6:0] = 7'b0110011;
        1: ins[6:0] = 7'b0010011;
        2: ins[6:0] = 7'b0110111;
        3: ins[6:0] = 7'b0010111;
        4: begin ins[6:0] = 7'b0110011; ins[31:25] = 7'h20; end
        default: ;
      endcase
      if ($urandom_range(0, 2) == 0) ins[31:25] = 7'h00;
      v  = (i < 390) && ($urandom_range(0, 3) != 0);
      fl = (i < 390) && ($urandom_range(0, 31) == 0);
      step(v, ins, pc, r1, r2, model(ins, pc, r1, r2), (i >= 390) || $urandom_range(0, 2) != 0,
           fl, rdy, p, g, e);
      if (p) begin
        n_chk++;
        if (g !== e) begin n_fail++; $display("FAIL random[%0d]: got %h exp %h", i, g, e); end
      end
    end
    n_chk++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d pending, out_valid=%b exp 0/0", sb.size(), out_valid);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
